// File: rtl/io_cycle_ctrl_if.sv
// Signal bundle between the CPU-side decoder, io_cycle_ctrl and the peripheral port.
// Board net names are kept so schematics and RTL read the same.
interface io_cycle_ctrl_if #(
    parameter int PORT_W = 16,
    parameter int NUM_CS = 3
);
    logic              _AS;
    logic              R_W;
    logic [NUM_CS-1:0] _CS_REQ;
    logic [31:0]       DATA_IN;
    logic [31:0]       DATA_OUT;
    logic              DATA_OE;
    logic [1:0]        _DSACK;
    logic              _IORDY;
    logic              _IOR;
    logic              _IOW;
    logic [NUM_CS-1:0] _CS_OUT;
    logic [PORT_W-1:0] PD_IN;
    logic [PORT_W-1:0] PD_OUT;
    logic              PD_OE;
    logic              TIMEOUT_ERR;

    modport master (
        output _AS, R_W, _CS_REQ, DATA_IN, _IORDY, PD_IN,
        input  DATA_OUT, DATA_OE, _DSACK, _IOR, _IOW, _CS_OUT, PD_OUT, PD_OE, TIMEOUT_ERR
    );

    modport slave (
        input  _AS, R_W, _CS_REQ, DATA_IN, _IORDY, PD_IN,
        output DATA_OUT, DATA_OE, _DSACK, _IOR, _IOW, _CS_OUT, PD_OUT, PD_OE, TIMEOUT_ERR
    );
endinterface

// File: rtl/io_cycle_ctrl.sv
// Timed 8/16-bit peripheral cycle generator with setup/strobe/hold, IORDY wait,
// timeout and 68030 dynamic-bus-sizing acknowledge. All outputs are registered.
module io_cycle_ctrl #(
    parameter int PORT_W     = 16,
    parameter int NUM_CS     = 3,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1,
    parameter int TIMEOUT    = 255
) (
    input logic            SCLK,
    input logic            _RST,
    io_cycle_ctrl_if.slave bus
);
    localparam int MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int MAX_SSH = (MAX_SH > STROBE_CYC) ? MAX_SH : STROBE_CYC;
    localparam int MAX_CYC = (MAX_SSH > TIMEOUT) ? MAX_SSH : TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0]       DSACK_ACT    = (PORT_W == 8) ? 2'b10 : 2'b01;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        WAIT   = 3'd3,
        HOLD   = 3'd4,
        ACK    = 3'd5
    } state_e;

    // Byte lanes the 68030 expects for an 8- or 16-bit port: replicate across 32 bits.
    function automatic logic [31:0] widen_pd(input logic [PORT_W-1:0] pd);
        return {(32 / PORT_W){pd}};
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rd_q, rd_d;
    logic [NUM_CS-1:0]  sel_q, sel_d;
    logic               ior_n_q, ior_n_d;
    logic               iow_n_q, iow_n_d;
    logic [NUM_CS-1:0]  cs_out_n_q, cs_out_n_d;
    logic [1:0]         dsack_n_q, dsack_n_d;
    logic [31:0]        data_out_q, data_out_d;
    logic               data_oe_q, data_oe_d;
    logic [PORT_W-1:0]  pd_out_q, pd_out_d;
    logic               pd_oe_q, pd_oe_d;
    logic               timeout_err_q, timeout_err_d;

    logic [NUM_CS-1:0]  req_s, req_low_s;
    logic [PORT_W-1:0]  pd_lat_s;
    logic               capture_s, active_s, strobe_s;

    // Active requests, and the lowest-index one isolated as a one-hot mask.
    always_comb begin
        req_s     = ~bus._CS_REQ;
        req_low_s = req_s & (~req_s + NUM_CS'(1));
    end

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_d          = rd_q;
        sel_d         = sel_q;
        pd_lat_s      = pd_out_q;
        capture_s     = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus._AS && (req_s != {NUM_CS{1'b0}})) begin
                    state_d  = SETUP;
                    cnt_d    = {CNT_W{1'b0}};
                    rd_d     = bus.R_W;
                    sel_d    = req_low_s;
                    pd_lat_s = bus.DATA_IN[31 -: PORT_W];
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (bus._AS) begin
                    state_d = IDLE;
                end else if (cnt_q == SETUP_LAST) begin
                    state_d = STROBE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STROBE: begin
                if (bus._AS) begin
                    state_d = IDLE;
                end else if (cnt_q == STROBE_LAST) begin
                    state_d   = bus._IORDY ? HOLD : WAIT;
                    cnt_d     = {CNT_W{1'b0}};
                    capture_s = bus._IORDY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                // Abort wins over timeout so an abandoned cycle never flags an error.
                if (bus._AS) begin
                    state_d = IDLE;
                end else if (bus._IORDY || (cnt_q == TIMEOUT_LAST)) begin
                    state_d       = HOLD;
                    cnt_d         = {CNT_W{1'b0}};
                    capture_s     = 1'b1;
                    timeout_err_d = !bus._IORDY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (bus._AS) begin
                    state_d = IDLE;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ACK;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK: begin
                if (bus._AS) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) begin
            cnt_d      = {CNT_W{1'b0}};
            pd_out_d   = {PORT_W{1'b0}};
            data_out_d = {32{1'b0}};
        end else if (capture_s && rd_q) begin
            pd_out_d   = pd_lat_s;
            data_out_d = widen_pd(bus.PD_IN);
        end else begin
            pd_out_d   = pd_lat_s;
            data_out_d = data_out_q;
        end

        active_s   = state_d inside {SETUP, STROBE, WAIT, HOLD};
        strobe_s   = state_d inside {STROBE, WAIT};
        ior_n_d    = !(strobe_s && rd_d);
        iow_n_d    = !(strobe_s && !rd_d);
        cs_out_n_d = active_s ? ~sel_d : {NUM_CS{1'b1}};
        pd_oe_d    = active_s && !rd_d;
        dsack_n_d  = (state_d == ACK) ? DSACK_ACT : 2'b11;
        data_oe_d  = (state_d == ACK) && rd_d;
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge SCLK) begin
        if (!_RST) begin
            state_q       <= IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            rd_q          <= 1'b0;
            sel_q         <= {NUM_CS{1'b0}};
            ior_n_q       <= 1'b1;
            iow_n_q       <= 1'b1;
            cs_out_n_q    <= {NUM_CS{1'b1}};
            dsack_n_q     <= 2'b11;
            data_out_q    <= {32{1'b0}};
            data_oe_q     <= 1'b0;
            pd_out_q      <= {PORT_W{1'b0}};
            pd_oe_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_q          <= rd_d;
            sel_q         <= sel_d;
            ior_n_q       <= ior_n_d;
            iow_n_q       <= iow_n_d;
            cs_out_n_q    <= cs_out_n_d;
            dsack_n_q     <= dsack_n_d;
            data_out_q    <= data_out_d;
            data_oe_q     <= data_oe_d;
            pd_out_q      <= pd_out_d;
            pd_oe_q       <= pd_oe_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus._IOR        = ior_n_q;
    assign bus._IOW        = iow_n_q;
    assign bus._CS_OUT     = cs_out_n_q;
    assign bus._DSACK      = dsack_n_q;
    assign bus.DATA_OUT    = data_out_q;
    assign bus.DATA_OE     = data_oe_q;
    assign bus.PD_OUT      = pd_out_q;
    assign bus.PD_OE       = pd_oe_q;
    assign bus.TIMEOUT_ERR = timeout_err_q;
endmodule
